// File: rtl/pe_mac_stream.sv
// Signed fixed-point MAC over a runtime-length window, preloaded with bias; the last beat rounds,
// applies optional ReLU, saturates and loads a registered valid/ready result (1-cycle latency).
module pe_mac_stream #(
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 3,
  parameter int ACC_W     = 20,
  parameter int LEN_W     = 11
) (
  input  logic                     clk_cal,
  input  logic                     rst_cal,
  input  logic [LEN_W-1:0]         cfg_len_m1,
  input  logic                     cfg_relu,
  input  logic                     acc_clr,
  input  logic signed [DATA_W-1:0] IMap,
  input  logic signed [DATA_W-1:0] IWeight,
  input  logic                     ImapVld,
  input  logic                     IweightVld,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     in_rdy,
  output logic signed [DATA_W-1:0] OMap,
  output logic                     OMapVld,
  input  logic                     OMapRdy,
  output logic                     sat_flag
);
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] ACC_MAX = SW'((longint'(1) <<< (ACC_W-1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = SW'(-(longint'(1) <<< (ACC_W-1)));
  localparam logic signed [SW-1:0] OUT_MAX = SW'((longint'(1) <<< (DATA_W-1)) - 1);
  localparam logic signed [SW-1:0] OUT_MIN = SW'(-(longint'(1) <<< (DATA_W-1)));
  localparam logic signed [SW-1:0] RND     = SW'(longint'(1) <<< (FRAC_BITS-1));

  logic [LEN_W-1:0]         r_cnt;
  logic [LEN_W-1:0]         r_len_m1;
  logic                     r_relu;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_ovf;
  logic signed [DATA_W-1:0] r_omap;
  logic                     r_omap_vld;
  logic                     r_sat;

  logic                     w_first;
  logic [LEN_W-1:0]         w_len_m1;
  logic                     w_relu;
  logic                     w_last;
  logic                     w_accept;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [SW-1:0]     w_sum;
  logic                     w_acc_hit;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic                     w_ovf_nxt;
  logic signed [SW-1:0]     w_rnd;
  logic signed [SW-1:0]     w_clip;
  logic                     w_clamp_hit;
  logic signed [DATA_W-1:0] w_out;

  // A full output register that the consumer is not taking this cycle stalls the operand bus.
  assign in_rdy   = !(r_omap_vld && !OMapRdy);
  assign OMap     = r_omap;
  assign OMapVld  = r_omap_vld;
  assign sat_flag = r_sat;

  always_comb begin
    w_first   = (r_cnt == '0);
    // Config is taken live on the first beat so a single-beat window sees it immediately.
    w_len_m1  = w_first ? cfg_len_m1 : r_len_m1;
    w_relu    = w_first ? cfg_relu : r_relu;
    w_last    = (r_cnt == w_len_m1);
    w_accept  = ImapVld && IweightVld && in_rdy && !acc_clr;
    w_prod    = IMap * IWeight;
    w_base    = w_first ? (ACC_W'(bias) <<< FRAC_BITS) : r_acc;
    w_sum     = SW'(w_base) + SW'(w_prod);
    w_acc_hit = (w_sum > ACC_MAX) || (w_sum < ACC_MIN);
    if (w_sum > ACC_MAX)
      w_acc_nxt = ACC_MAX[ACC_W-1:0];
    else if (w_sum < ACC_MIN)
      w_acc_nxt = ACC_MIN[ACC_W-1:0];
    else
      w_acc_nxt = w_sum[ACC_W-1:0];
    w_ovf_nxt   = (!w_first && r_ovf) || w_acc_hit;
    w_rnd       = (SW'(w_acc_nxt) + RND) >>> FRAC_BITS;
    w_clip      = (w_relu && w_rnd[SW-1]) ? '0 : w_rnd;
    w_clamp_hit = (w_clip > OUT_MAX) || (w_clip < OUT_MIN);
    if (w_clip > OUT_MAX)
      w_out = OUT_MAX[DATA_W-1:0];
    else if (w_clip < OUT_MIN)
      w_out = OUT_MIN[DATA_W-1:0];
    else
      w_out = w_clip[DATA_W-1:0];
  end

  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      r_cnt      <= '0;
      r_len_m1   <= '0;
      r_relu     <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_omap     <= '0;
      r_omap_vld <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      if (acc_clr) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        if (w_first) begin
          r_len_m1 <= cfg_len_m1;
          r_relu   <= cfg_relu;
        end
        r_acc <= w_acc_nxt;
        r_ovf <= w_last ? 1'b0 : w_ovf_nxt;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      // A fresh result wins over a drain in the same cycle, so nothing is lost.
      if (w_accept && w_last) begin
        r_omap     <= w_out;
        r_sat      <= w_ovf_nxt || w_clamp_hit;
        r_omap_vld <= 1'b1;
      end else if (r_omap_vld && OMapRdy) begin
        r_omap_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Bench for pe_mac_stream: fixed vector table, hand-written multi-cycle sequences, and a
// randomized run scored against a window-level arithmetic model.
module tb_pe_mac_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] cfg_len_m1;
  logic        cfg_relu, acc_clr;
  logic [7:0]  imap, iw, bias;
  logic        ivld, wvld, omap_rdy;
  logic        in_rdy, omap_vld, sat;
  logic [7:0]  omap;
  logic        in_rdy16, omap_vld16, sat16;
  logic [7:0]  omap16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_mac_stream dut (
    .clk_cal(clk), .rst_cal(rst), .cfg_len_m1(cfg_len_m1), .cfg_relu(cfg_relu),
    .acc_clr(acc_clr), .IMap(imap), .IWeight(iw), .ImapVld(ivld), .IweightVld(wvld),
    .bias(bias), .in_rdy(in_rdy), .OMap(omap), .OMapVld(omap_vld), .OMapRdy(omap_rdy),
    .sat_flag(sat)
  );

  pe_mac_stream #(.ACC_W(16)) dut16 (
    .clk_cal(clk), .rst_cal(rst), .cfg_len_m1(cfg_len_m1), .cfg_relu(cfg_relu),
    .acc_clr(acc_clr), .IMap(imap), .IWeight(iw), .ImapVld(ivld), .IweightVld(wvld),
    .bias(bias), .in_rdy(in_rdy16), .OMap(omap16), .OMapVld(omap_vld16), .OMapRdy(omap_rdy),
    .sat_flag(sat16)
  );

  typedef struct {
    int         len;
    bit         relu;
    int         bias;
    int         a;
    int         b;
    logic [7:0] om;
    bit         sat;
  } vec_t;

  vec_t tbl[10];

  int qa[$];
  int qb[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Window result from plain integer arithmetic: bias*2^F, saturating sums, round-half-up, relu, clamp.
  function automatic logic [8:0] ref_win(input int accw, input int nb, input int bi, input bit relu);
    longint hi, lo, acc, t;
    bit     ovf;
    bit     clamp;
    logic [7:0] o;
    hi  = (longint'(1) <<< (accw - 1)) - 1;
    lo  = -hi - 1;
    acc = longint'(bi) * 8;
    ovf = 1'b0;
    for (int i = 0; i < nb; i++) begin
      acc = acc + longint'(qa[i]) * longint'(qb[i]);
      if (acc > hi) begin acc = hi; ovf = 1'b1; end
      else if (acc < lo) begin acc = lo; ovf = 1'b1; end
    end
    t = (acc + 4) >>> 3;
    if (relu && t < 0) t = 0;
    clamp = 1'b0;
    if (t > 127) begin t = 127; clamp = 1'b1; end
    else if (t < -128) begin t = -128; clamp = 1'b1; end
    o = 8'(t);
    return {ovf | clamp, o};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    cfg_len_m1 = 11'(v.len);
    cfg_relu   = v.relu;
    bias       = 8'(v.bias);
    imap       = 8'(v.a);
    iw         = 8'(v.b);
    omap_rdy   = 1'b1;
    ivld       = 1'b1;
    wvld       = 1'b1;
    for (int i = 0; i <= v.len; i++) begin
      step();
      if (i < v.len) chk($sformatf("vec%0d_early_vld", idx), omap_vld, 1'b0);
    end
    chk($sformatf("vec%0d_vld", idx), omap_vld, 1'b1);
    chk($sformatf("vec%0d_omap", idx), omap, v.om);
    chk($sformatf("vec%0d_sat", idx), sat, v.sat);
    ivld = 1'b0;
    wvld = 1'b0;
    step();
    chk($sformatf("vec%0d_drained", idx), omap_vld, 1'b0);
  endtask

  initial begin
    int         m_cnt, m_len, m_bias;
    bit         m_relu, m_vld, m_sat, exp_rdy, load;
    logic [7:0] m_omap;
    logic [8:0] res;
    int         sa[5];
    int         sb[5];

    tbl[0] = '{2, 1'b0,  8,    8,   8, 8'd32,  1'b0};
    tbl[1] = '{0, 1'b0,  0,    2,   2, 8'd1,   1'b0};
    tbl[2] = '{0, 1'b0,  0,    3,   1, 8'd0,   1'b0};
    tbl[3] = '{0, 1'b0,  0,   -3,   1, 8'd0,   1'b0};
    tbl[4] = '{0, 1'b0,  0,   -5,   1, 8'hFF,  1'b0};
    tbl[5] = '{0, 1'b1,  0,   -8,   8, 8'h00,  1'b0};
    tbl[6] = '{0, 1'b0,  0,   -8,   8, 8'hF8,  1'b0};
    tbl[7] = '{3, 1'b0,  0,  127, 127, 8'h7F,  1'b1};
    tbl[8] = '{3, 1'b0,  0, -128, 127, 8'h80,  1'b1};
    tbl[9] = '{1, 1'b0, -8,   16,   4, 8'd8,   1'b0};

    rst = 1'b1; cfg_len_m1 = '0; cfg_relu = 1'b0; acc_clr = 1'b0;
    imap = '0; iw = '0; bias = '0; ivld = 1'b0; wvld = 1'b0; omap_rdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_omap", omap, 8'd0);
    chk("rst_vld", omap_vld, 1'b0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_in_rdy16", in_rdy16, 1'b1);

    for (int k = 0; k < 10; k++) run_vec(tbl[k], k);

    // Config change after the first beat must not affect the window.
    cfg_len_m1 = 11'd3; cfg_relu = 1'b1; bias = 8'd0; imap = 8'hF8; iw = 8'd8;
    ivld = 1'b1; wvld = 1'b1; omap_rdy = 1'b1;
    step();
    cfg_relu = 1'b0; cfg_len_m1 = 11'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("relu_tog_early", omap_vld, 1'b0);
    end
    step();
    chk("relu_tog_vld", omap_vld, 1'b1);
    chk("relu_tog_omap", omap, 8'h00);
    ivld = 1'b0; wvld = 1'b0;
    step();

    // Accumulator clamp alone drives sat_flag in the narrow instance.
    sa = '{127, 127, 127, -128, -128};
    sb = '{127, 127, 127, 127, 127};
    cfg_len_m1 = 11'd4; cfg_relu = 1'b0; bias = 8'd0; ivld = 1'b1; wvld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imap = 8'(sa[i]); iw = 8'(sb[i]);
      step();
    end
    chk("acc16_vld", omap_vld16, 1'b1);
    chk("acc16_omap", omap16, 8'd32);
    chk("acc16_sat", sat16, 1'b1);
    chk("acc20_omap", omap, 8'h7F);
    chk("acc20_sat", sat, 1'b1);
    ivld = 1'b0; wvld = 1'b0;
    step();

    // Backpressure: hold, release, then loads coinciding with drains.
    cfg_len_m1 = 11'd1; bias = 8'd0; imap = 8'd8; iw = 8'd8; omap_rdy = 1'b0;
    ivld = 1'b1; wvld = 1'b1;
    step();
    step();
    chk("bp_vld", omap_vld, 1'b1);
    chk("bp_omap", omap, 8'd16);
    imap = 8'd8; iw = 8'd16;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_rdy", in_rdy, 1'b0);
      chk("bp_hold_vld", omap_vld, 1'b1);
      chk("bp_hold_omap", omap, 8'd16);
    end
    omap_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", in_rdy, 1'b1);
    step();
    chk("bp_drain_vld", omap_vld, 1'b0);
    step();
    chk("bp_w2_vld", omap_vld, 1'b1);
    chk("bp_w2_omap", omap, 8'd32);
    cfg_len_m1 = 11'd0; imap = 8'd8; iw = 8'd8;
    step();
    chk("stream1_vld", omap_vld, 1'b1);
    chk("stream1_omap", omap, 8'd8);
    imap = 8'd16;
    step();
    chk("stream2_vld", omap_vld, 1'b1);
    chk("stream2_omap", omap, 8'd16);
    ivld = 1'b0; wvld = 1'b0;
    step();
    chk("stream_end_vld", omap_vld, 1'b0);

    // Abort after two beats; the beat coinciding with acc_clr is dropped.
    cfg_len_m1 = 11'd4; bias = 8'd0; imap = 8'd8; iw = 8'd8; ivld = 1'b1; wvld = 1'b1;
    step(); step();
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_early_vld", omap_vld, 1'b0);
    end
    step();
    chk("abort_vld", omap_vld, 1'b1);
    chk("abort_omap", omap, 8'd40);
    ivld = 1'b0; wvld = 1'b0;
    step();

    // Reset mid-window, then a full window.
    cfg_len_m1 = 11'd2; bias = 8'd8; ivld = 1'b1; wvld = 1'b1;
    step(); step();
    rst = 1'b1; ivld = 1'b0; wvld = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_omap", omap, 8'd0);
    chk("midrst_vld", omap_vld, 1'b0);
    chk("midrst_sat", sat, 1'b0);
    chk("midrst_in_rdy", in_rdy, 1'b1);
    step();
    chk("midrst_idle_vld", omap_vld, 1'b0);
    ivld = 1'b1; wvld = 1'b1;
    step(); step(); step();
    chk("postrst_vld", omap_vld, 1'b1);
    chk("postrst_omap", omap, 8'd32);
    ivld = 1'b0; wvld = 1'b0;

    // Randomized run from a clean reset against the window model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cnt = 0; m_len = 0; m_bias = 0; m_relu = 1'b0;
    m_vld = 1'b0; m_sat = 1'b0; m_omap = '0;
    qa.delete(); qb.delete();
    for (int c = 0; c < 800; c++) begin
      ivld       = ($urandom_range(0, 3) != 0);
      wvld       = ($urandom_range(0, 3) != 0);
      imap       = 8'($urandom);
      iw         = 8'($urandom);
      bias       = 8'($urandom);
      cfg_len_m1 = 11'($urandom_range(0, 3));
      cfg_relu   = 1'($urandom_range(0, 1));
      acc_clr    = ($urandom_range(0, 31) == 0);
      omap_rdy   = ($urandom_range(0, 9) < 6);
      #1;
      exp_rdy = !(m_vld && !omap_rdy);
      chk("rnd_in_rdy", in_rdy, exp_rdy);
      load = 1'b0;
      res  = '0;
      if (acc_clr) begin
        m_cnt = 0;
        qa.delete(); qb.delete();
      end else if (ivld && wvld && exp_rdy) begin
        if (m_cnt == 0) begin
          m_len  = int'(cfg_len_m1);
          m_relu = cfg_relu;
          m_bias = int'($signed(bias));
        end
        qa.push_back(int'($signed(imap)));
        qb.push_back(int'($signed(iw)));
        m_cnt++;
        if (m_cnt == m_len + 1) begin
          res  = ref_win(20, m_cnt, m_bias, m_relu);
          load = 1'b1;
          m_cnt = 0;
          qa.delete(); qb.delete();
        end
      end
      if (load) begin
        m_vld  = 1'b1;
        m_omap = res[7:0];
        m_sat  = res[8];
      end else if (m_vld && omap_rdy) begin
        m_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rnd_vld", omap_vld, m_vld);
      if (m_vld) begin
        chk("rnd_omap", omap, m_omap);
        chk("rnd_sat", sat, m_sat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
